// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-nibble sequencer for an external 4-bit combinational ALU.
// Accepts one command on W = 4*NIBBLES-bit operands and walks the ALU across
// the operands one nibble per cycle, LSB nibble first, chaining carry via alu_cin.
// Result and flags are held until the next accepted command.
//
// Optional feature: define ALU_SEQ_OVF_EN to add the flag_v output, which is
// signed overflow for ADD/ADC/INC.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   start, cmd, op_a, op_b  command request, opcode and operands
//   cin_in                  initial carry for ADC
//   busy, done              running indicator / one-cycle completion pulse
//   result, flag_z/c/s      W-bit result and zero/carry/sign flags
//   flag_v                  signed overflow (only with ALU_SEQ_OVF_EN)
//   alu_a/b/cin/op/l        drive to the external ALU (0 when not running)
//   alu_r/z/c/s             sampled outputs of the external ALU
module alu_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2:0]             cmd,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic                   flag_s,
`ifdef ALU_SEQ_OVF_EN
    output logic                   flag_v,
`endif
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_cin,
    output logic [1:0]             alu_op,
    output logic                   alu_l,
    input  logic [3:0]             alu_r,
    input  logic                   alu_z,
    input  logic                   alu_c,
    input  logic                   alu_s
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_ADC  = 3'd1;
    localparam logic [2:0] CMD_INC  = 3'd2;
    localparam logic [2:0] CMD_AND  = 3'd3;
    localparam logic [2:0] CMD_OR   = 3'd4;
    localparam logic [2:0] CMD_XOR  = 3'd5;
    localparam logic [2:0] CMD_NOT  = 3'd6;
    localparam logic [2:0] CMD_PASS = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t next_state;
    logic   accept;
    logic   last;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             arith_q;
    logic             zacc_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;

    // Arithmetic commands chain carry and report it; logic commands do not.
    function automatic logic is_arith(input logic [2:0] c);
        return (c == CMD_ADD) || (c == CMD_ADC) || (c == CMD_INC);
    endfunction

    // INC and PASS feed B=0 so the ALU adds/ORs against nothing.
    function automatic logic zero_b(input logic [2:0] c);
        return (c == CMD_INC) || (c == CMD_PASS);
    endfunction

    // ALU opcode per command; PASS is OR with B=0.
    function automatic logic [1:0] op_of(input logic [2:0] c);
        logic [1:0] op;
        case (c)
            CMD_AND:  op = 2'b00;
            CMD_OR:   op = 2'b01;
            CMD_XOR:  op = 2'b10;
            CMD_NOT:  op = 2'b11;
            CMD_PASS: op = 2'b01;
            default:  op = 2'b10;
        endcase
        return op;
    endfunction

    assign idx_nxt = idx_q + IDX_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        next_state = state_q;
        accept     = 1'b0;
        last       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_IDX) begin
                    last       = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = S_RUN;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: operand latch, nibble walk, result/flag capture and ALU drive.
    // alu_* are registered one cycle ahead so they present nibble[idx] during RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_s  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            flag_v  <= 1'b0;
`endif
            alu_a   <= 4'h0;
            alu_b   <= 4'h0;
            alu_cin <= 1'b0;
            alu_op  <= 2'b00;
            alu_l   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            arith_q <= 1'b0;
            zacc_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            busy <= (next_state == S_RUN);
            done <= (next_state == S_DONE);
            if (accept) begin
                a_q     <= op_a;
                b_q     <= zero_b(cmd) ? '0 : op_b;
                arith_q <= is_arith(cmd);
                zacc_q  <= 1'b1;
                idx_q   <= '0;
                result  <= '0;
                alu_a   <= op_a[3:0];
                alu_b   <= zero_b(cmd) ? 4'h0 : op_b[3:0];
                alu_cin <= (cmd == CMD_ADC) ? cin_in : (cmd == CMD_INC);
                alu_op  <= op_of(cmd);
                alu_l   <= ~is_arith(cmd);
            end else if (state_q == S_RUN) begin
                result <= result | (W'(alu_r) << {idx_q, 2'b00});
                zacc_q <= zacc_q & alu_z;
                if (last) begin
                    idx_q   <= '0;
                    flag_z  <= zacc_q & alu_z;
                    flag_c  <= arith_q & alu_c;
                    flag_s  <= alu_s;
`ifdef ALU_SEQ_OVF_EN
                    // Same-sign operands producing a different-sign result.
                    flag_v  <= arith_q && (a_q[W-1] == b_q[W-1]) && (alu_r[3] != a_q[W-1]);
`endif
                    alu_a   <= 4'h0;
                    alu_b   <= 4'h0;
                    alu_cin <= 1'b0;
                    alu_op  <= 2'b00;
                    alu_l   <= 1'b0;
                end else begin
                    idx_q   <= idx_nxt;
                    alu_a   <= 4'(a_q >> {idx_nxt, 2'b00});
                    alu_b   <= 4'(b_q >> {idx_nxt, 2'b00});
                    alu_cin <= alu_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl (NIBBLES=4) with a
// behavioural model of the external 4-bit ALU.
module tb_alu_seq_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 16;

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_ADC  = 3'd1;
    localparam logic [2:0] C_INC  = 3'd2;
    localparam logic [2:0] C_AND  = 3'd3;
    localparam logic [2:0] C_OR   = 3'd4;
    localparam logic [2:0] C_XOR  = 3'd5;
    localparam logic [2:0] C_NOT  = 3'd6;
    localparam logic [2:0] C_PASS = 3'd7;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [2:0]   cmd;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_z;
    logic         flag_c;
    logic         flag_s;
    logic         flag_v;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_cin;
    logic [1:0]   alu_op;
    logic         alu_l;
    logic [3:0]   alu_r;
    logic         alu_z;
    logic         alu_c;
    logic         alu_s;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .cmd     (cmd),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin_in  (cin_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_s  (flag_s),
`ifdef ALU_SEQ_OVF_EN
        .flag_v  (flag_v),
`endif
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_cin (alu_cin),
        .alu_op  (alu_op),
        .alu_l   (alu_l),
        .alu_r   (alu_r),
        .alu_z   (alu_z),
        .alu_c   (alu_c),
        .alu_s   (alu_s)
    );

`ifndef ALU_SEQ_OVF_EN
    assign flag_v = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit ALU: l=0 add with carry, l=1 logic op selected by alu_op.
    always_comb begin
        logic [4:0] sum;
        sum   = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
        alu_r = 4'h0;
        alu_c = 1'b0;
        if (!alu_l) begin
            alu_r = sum[3:0];
            alu_c = sum[4];
        end else begin
            case (alu_op)
                2'b00:   alu_r = alu_a & alu_b;
                2'b01:   alu_r = alu_a | alu_b;
                2'b10:   alu_r = alu_a ^ alu_b;
                default: alu_r = ~alu_a;
            endcase
        end
        alu_z = (alu_r == 4'h0);
        alu_s = alu_r[3];
    end

    typedef struct {
        logic [2:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] r;
        logic         z;
        logic         cy;
        logic         s;
        logic         v;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic launch(input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci);
        start  = 1'b1;
        cmd    = c;
        op_a   = a;
        op_b   = b;
        cin_in = ci;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Edges from now until done is seen (0 if it never comes within budget).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int n = 1; n <= 12; n++) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // W-bit reference: returns {v, c, z, s, result}.
    function automatic logic [19:0] ref_model(input logic [2:0] c, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic ci);
        logic [W:0]   s17;
        logic [W-1:0] r;
        logic         cy;
        logic         v;
        logic [W-1:0] bb;
        cy = 1'b0;
        v  = 1'b0;
        bb = (c == C_INC) ? '0 : b;
        case (c)
            C_ADD:   s17 = 17'(a) + 17'(b);
            C_ADC:   s17 = 17'(a) + 17'(b) + 17'(ci);
            C_INC:   s17 = 17'(a) + 17'd1;
            default: s17 = '0;
        endcase
        case (c)
            C_AND:   r = a & b;
            C_OR:    r = a | b;
            C_XOR:   r = a ^ b;
            C_NOT:   r = ~a;
            C_PASS:  r = a;
            default: begin
                r  = s17[W-1:0];
                cy = s17[W];
                v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
            end
        endcase
        return {v, cy, (r == '0), r[W-1], r};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcnt;
        logic [19:0] exp;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        vecs[0]  = '{C_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{C_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{C_ADC,  16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{C_INC,  16'h7FFF, 16'h1111, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{C_NOT,  16'h0F0F, 16'h1234, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{C_PASS, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{C_AND,  16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{C_OR,   16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{C_XOR,  16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{C_ADD,  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{C_INC,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{C_ADC,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{C_ADD,  16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{C_PASS, 16'h1234, 16'hFFFF, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{C_AND,  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{C_ADD,  16'h0FFF, 16'hF001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        cmd     = 3'd0;
        op_a    = '0;
        op_b    = '0;
        cin_in  = 1'b0;

        // Reset state
        #12;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags",  32'({flag_z, flag_c, flag_s, flag_v}), 32'd0);
        chk("rst_alu",    32'({alu_a, alu_b, alu_cin, alu_op, alu_l}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            launch(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].ci);
            wait_done(lat, bcnt);
            chk($sformatf("v%0d_latency", i), 32'(lat),  32'd4);
            chk($sformatf("v%0d_busy",    i), 32'(bcnt), 32'd4);
            chk($sformatf("v%0d_result",  i), 32'(result), 32'(vecs[i].r));
            chk($sformatf("v%0d_zcs",     i), 32'({flag_z, flag_c, flag_s}),
                32'({vecs[i].z, vecs[i].cy, vecs[i].s}));
`ifdef ALU_SEQ_OVF_EN
            chk($sformatf("v%0d_v",       i), 32'(flag_v), 32'(vecs[i].v));
`endif
            chk($sformatf("v%0d_alu_idle", i), 32'({alu_a, alu_b, alu_cin, alu_op, alu_l}), 32'd0);
        end

        // Back-to-back: ADC then XOR started in the DONE cycle
        @(posedge clk);
        #1;
        launch(C_ADC, 16'h1234, 16'h0000, 1'b1);
        wait_done(lat, bcnt);
        chk("b2b_first_result", 32'(result), 32'h1235);
        launch(C_XOR, 16'hA5A5, 16'hFFFF, 1'b0);
        chk("b2b_busy_after_start", 32'(busy), 32'd1);
        chk("b2b_done_dropped",     32'(done), 32'd0);
        wait_done(lat, bcnt);
        chk("b2b_done_spacing", 32'(lat + 1), 32'd5);
        chk("b2b_result", 32'(result), 32'h5A5A);
        chk("b2b_cs", 32'({flag_c, flag_s}), 32'd0);

        // start pulsed during RUN is ignored and not queued
        @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);
        launch(C_ADD, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        cmd   = C_XOR;
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_latency", 32'(lat), 32'd2);
        chk("ign_result",  32'(result), 32'h0100);
        @(posedge clk);
        #1;
        chk("ign_not_queued", 32'({busy, done}), 32'd0);
        chk("ign_result_held", 32'(result), 32'h0100);

        // Reset in the middle of RUN
        launch(C_ADD, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_partial", 32'(result), 32'h0005);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy_done", 32'({busy, done}), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_alu", 32'({alu_a, alu_b, alu_cin, alu_op, alu_l}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_idle", 32'({busy, done}), 32'd0);
        launch(C_ADD, 16'h0001, 16'h0001, 1'b0);
        wait_done(lat, bcnt);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_result", 32'(result), 32'h0002);

        // Random operands per command against the W-bit reference
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 200; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                exp = ref_model(3'(c), ra, rb, rc);
                launch(3'(c), ra, rb, rc);
                wait_done(lat, bcnt);
                chk($sformatf("rnd_c%0d_%0d a=%0h b=%0h", c, k, ra, rb),
                    32'({lat[3:0], flag_c, flag_z, flag_s, result}),
                    32'({4'd4, exp[18:0]}));
`ifdef ALU_SEQ_OVF_EN
                chk($sformatf("rnd_v_c%0d_%0d", c, k), 32'(flag_v), 32'(exp[19]));
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
